// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem request per PC,
// holds the returned instruction and steers the PC register.
module inst_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] PC,
    output logic [ADDR_WIDTH-1:0] PCNext,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0] state;
    logic [2:0] state_next;
    logic       resp_take;

    assign imem_req_addr  = PC;
    assign imem_req_valid = (state == REQ);

    // A redirect in WAIT squashes the returning data.
    assign resp_take = (state == WAIT) && imem_resp_valid && !redirect_valid;

    always_comb begin
        PCNext = PC;
        if (redirect_valid) begin
            PCNext = redirect_pc;
        end else if (resp_take) begin
            PCNext = PC + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    state_next = redirect_valid ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    state_next = redirect_valid ? REQ : HOLD;
                end else if (redirect_valid) begin
                    state_next = DRAIN;
                end
            end
            HOLD: begin
                if (redirect_valid || inst_ready) begin
                    state_next = REQ;
                end
            end
            DRAIN: begin
                if (imem_resp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_next;
            inst_valid <= (state_next == HOLD);
            if (resp_take) begin
                inst_out <= imem_resp_data;
                inst_pc  <= PC;
            end
        end
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage directly downstream of the PC register.
- Issues one instruction-memory request per PC over a valid/ready handshake and holds the returned instruction for the decode/execute side under its own valid/ready handshake.
- Computes `PCNext` for the PC register (hold, +PC_STEP, or redirect target). The PC register loads every cycle, so holding is done by returning the current PC.
- Sequential core: a 5-state FSM plus instruction/PC holding registers.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- PC  in  ADDR_WIDTH  current PC from the PC register.
- PCNext  out  ADDR_WIDTH  next PC to the PC register (combinational).
- redirect_valid  in  1  branch/jump redirect request, single-cycle pulse.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- imem_req_valid  out  1  memory request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  request address; always equal to PC.
- imem_resp_valid  in  1  read data valid, one cycle per accepted request.
- imem_resp_data  in  DATA_WIDTH  read data.
- inst_valid  out  1  fetched instruction valid.
- inst_ready  in  1  consumer accepts instruction.
- inst_out  out  DATA_WIDTH  fetched instruction (registered).
- inst_pc  out  ADDR_WIDTH  address of inst_out (registered).

Behaviour:
- **FSM states:** IDLE, REQ, WAIT, HOLD, DRAIN.
- **Reset:** rst low asynchronously forces state=IDLE, inst_valid=0, inst_out=0, inst_pc=0. All outputs are therefore 0 during reset, except PCNext and imem_req_addr, which follow the PC port.
- **Output decoding:**
  - imem_req_valid = (state==REQ).
  - imem_req_addr = PC.
  - inst_valid = (state==HOLD), registered alongside the state.
- **Outstanding requests:** at most one. imem_resp_valid is ignored in IDLE, REQ and HOLD.
- **PCNext priority:**
  1. redirect_valid → redirect_pc.
  2. Else, response accepted in WAIT → PC + PC_STEP, truncated to ADDR_WIDTH (0xFFFFFFFC + 4 wraps to 0x00000000).
  3. Else → PC.
- **Transitions without redirect:**
  - IDLE → REQ unconditionally (first request is one cycle after reset release).
  - REQ → WAIT when imem_req_ready=1; otherwise stay in REQ.
  - WAIT → HOLD when imem_resp_valid=1. Same edge: inst_out ← imem_resp_data, inst_pc ← PC, PC advances.
  - HOLD → REQ when inst_ready=1; otherwise hold inst_out and inst_pc stable.
- **Latency and throughput:**
  - Zero-wait memory (ready and resp in successive cycles): inst_valid rises 2 cycles after request issue.
  - Steady-state throughput: 1 instruction per 3 cycles with inst_ready held high.
- **Redirect (redirect_valid=1), per state:**
  - IDLE: go to REQ; PC loads the target.
  - REQ with imem_req_ready=0: stay in REQ; imem_req_addr changes to the target next cycle. Memory samples the address only on handshake.
  - REQ with imem_req_ready=1: the stale request is accepted → DRAIN.
  - WAIT with imem_resp_valid=1: drop the data (inst regs unchanged, no advance) → REQ.
  - WAIT with imem_resp_valid=0 → DRAIN.
  - HOLD: inst_valid cleared next edge, even if inst_ready=1 in the same cycle (instruction is not delivered) → REQ.
  - DRAIN: PC takes the new target. Stay in DRAIN unless imem_resp_valid=1, then → REQ.
- **DRAIN without redirect:** wait for imem_resp_valid, discard the data, → REQ. PC is not advanced.
- **Reset mid-operation:** any outstanding memory transaction is abandoned. The memory shares rst, so no stale response follows reset release.

Test Plan:
- Reset release with PC=0x00000000, zero-wait memory returning 0x00000013, inst_ready=1:
  - imem_req_valid rises 1 cycle after release.
  - inst_valid=1 with inst_out=0x00000013, inst_pc=0x0 two cycles later.
  - PCNext=0x4 on the response cycle.
  - Subsequent fetches at 0x4, 0x8 every 3 cycles.
- Back-pressure: imem_req_ready low 3 cycles, then inst_ready low 4 cycles.
  - imem_req_addr is held stable while imem_req_ready is low.
  - inst_out and inst_pc are held stable while inst_ready is low.
  - PCNext=PC in every stalled cycle.
  - No duplicate request is issued.
- Redirect to 0x100 while in WAIT, response arriving 2 cycles later:
  - The response is discarded; inst_valid never asserts for it.
  - The next request address is 0x100.
  - The next inst_pc is 0x100.
- Redirect to 0x200 in HOLD with inst_ready=1 in the same cycle:
  - inst_valid drops next cycle.
  - The next request is at 0x200; the held instruction is not counted as delivered.
- Wrap-around: PC=0xFFFFFFFC fetch completes → PCNext=0x00000000, and the next request address is 0x0.
- rst asserted asynchronously mid-WAIT (between clock edges):
  - inst_valid and imem_req_valid go low immediately.
  - After release, the sequence restarts from IDLE with a request at the PC register's reset value.
